// File: rtl/cmd_ctrl.sv
// Host-command controller: assembles framed command packets from the UART RX
// byte stream, dispatches them to the accelerator array and streams results
// (or a single ACK/NAK/status byte) back through the UART TX.
module cmd_ctrl #(
   parameter int PAYLOAD_BYTES = 4,
   parameter int RESULT_WORDS  = 16,
   parameter int TIMEOUT_CYC   = 50000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_valid,
   input  logic                       tx_busy,
   input  logic                       acc_done,
   input  logic [7:0]                 res_data,
   output logic [7:0]                 acc_addr,
   output logic [2:0]                 acc_op,
   output logic [8*PAYLOAD_BYTES-1:0] acc_payload,
   output logic                       acc_start,
   output logic                       acc_clear,
   output logic [7:0]                 res_sel,
   output logic [7:0]                 tx_data,
   output logic                       tx_send,
   output logic [7:0]                 status
);

   localparam int PW = 8 * PAYLOAD_BYTES;
   localparam int TW = $clog2(TIMEOUT_CYC);

   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [4:0]    CNT_LAST = 5'(PAYLOAD_BYTES + 2);
   localparam logic [8:0]    WORDS    = 9'(RESULT_WORDS);

   localparam logic [7:0] ACK     = 8'h06;
   localparam logic [7:0] NAK     = 8'h15;
   localparam logic [7:0] SIG_VAL = 8'hAA;

   typedef enum logic [2:0] {
      IDLE, LOAD, EXEC, WAIT_ACC, SEND, TX_HOLD, DONE
   } state_t;

   state_t        state;
   logic [4:0]    byte_cnt;
   logic [TW-1:0] tmo;
   logic [8:0]    words_left;
   logic [3:0]    timeout_cnt;
   logic [1:0]    last_err;
   logic          pkt_ok;
   logic          pkt_err;    // error seen in the packet currently in flight
   logic          res_mode;   // SEND streams res_data instead of the latched byte
   logic          sig;        // status shows the power-up signature until the first packet ends

   // Packet framing, dispatch and response FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: a reset mid-packet must also wipe the framing counters, or the next
         // address byte would be taken as payload; every register is cleared here.
         state       <= IDLE;
         byte_cnt    <= '0;
         tmo         <= '0;
         words_left  <= '0;
         timeout_cnt <= '0;
         last_err    <= '0;
         pkt_ok      <= 1'b0;
         pkt_err     <= 1'b0;
         res_mode    <= 1'b0;
         sig         <= 1'b1;
         acc_addr    <= '0;
         acc_op      <= '0;
         acc_payload <= '0;
         acc_start   <= 1'b0;
         acc_clear   <= 1'b0;
         res_sel     <= '0;
         tx_data     <= '0;
         tx_send     <= 1'b0;
         status      <= SIG_VAL;
      end else begin
         // NOTE: pulses default low with non-blocking assignments; a later assignment
         // in the same block wins, so each strobe lasts exactly one cycle.
         acc_start <= 1'b0;
         acc_clear <= 1'b0;
         tx_send   <= 1'b0;
         status    <= sig ? SIG_VAL : {timeout_cnt, last_err, state != IDLE, pkt_ok};

         case (state)
            IDLE: begin
               if (rx_valid) begin
                  acc_addr <= rx_data;
                  byte_cnt <= 5'd1;
                  tmo      <= '0;
                  pkt_err  <= 1'b0;
                  state    <= LOAD;
               end
            end

            LOAD: begin
               if (rx_valid) begin
                  tmo <= '0;
                  if (byte_cnt == 5'd1) begin
                     acc_op <= rx_data[2:0];
                  end else begin
                     acc_payload <= (acc_payload << 8) | PW'(rx_data);
                  end
                  byte_cnt <= byte_cnt + 5'd1;
                  if (byte_cnt + 5'd1 == CNT_LAST) begin
                     state <= EXEC;
                  end
               end else if (tmo == TMO_LAST) begin
                  state    <= IDLE;
                  last_err <= 2'b01;
                  pkt_ok   <= 1'b0;
                  sig      <= 1'b0;
                  if (timeout_cnt != 4'hF) begin
                     timeout_cnt <= timeout_cnt + 4'd1;
                  end
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end

            EXEC: begin
               res_mode   <= 1'b0;
               words_left <= 9'd1;
               state      <= SEND;
               case (acc_op)
                  3'd0, 3'd3: begin
                     acc_clear <= 1'b1;
                     tx_data   <= ACK;
                  end
                  3'd1: begin
                     tx_data <= status;
                  end
                  3'd2: begin
                     acc_start <= 1'b1;
                     state     <= WAIT_ACC;
                  end
                  default: begin
                     last_err <= 2'b10;
                     pkt_err  <= 1'b1;
                     tx_data  <= NAK;
                  end
               endcase
            end

            WAIT_ACC: begin
               if (acc_done) begin
                  res_sel    <= '0;
                  words_left <= WORDS;
                  res_mode   <= 1'b1;
                  state      <= SEND;
               end
            end

            SEND: begin
               if (!tx_busy) begin
                  tx_send <= 1'b1;
                  if (res_mode) begin
                     tx_data <= res_data;
                  end
                  state <= TX_HOLD;
               end
            end

            TX_HOLD: begin
               if (words_left == 9'd1) begin
                  state <= DONE;
               end else begin
                  words_left <= words_left - 9'd1;
                  res_sel    <= res_sel + 8'd1;
                  state      <= SEND;
               end
            end

            DONE: begin
               pkt_ok <= !pkt_err;
               sig    <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_ctrl.sv
// Directed self-checking bench for cmd_ctrl: ACC streaming, TX back-pressure,
// inter-byte timeout, NAK, STATUS signature and mid-packet resets.
module tb_cmd_ctrl;

   localparam int PB  = 4;
   localparam int RW  = 16;
   localparam int TMO = 20;

   logic          clk;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          tx_busy;
   logic          acc_done;
   logic [7:0]    res_data;
   logic [7:0]    acc_addr;
   logic [2:0]    acc_op;
   logic [8*PB-1:0] acc_payload;
   logic          acc_start;
   logic          acc_clear;
   logic [7:0]    res_sel;
   logic [7:0]    tx_data;
   logic          tx_send;
   logic [7:0]    status;

   // Result array model: byte i of the result is i ^ 5A.
   assign res_data = res_sel ^ 8'h5A;

   cmd_ctrl #(
      .PAYLOAD_BYTES(PB),
      .RESULT_WORDS (RW),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_busy    (tx_busy),
      .acc_done   (acc_done),
      .res_data   (res_data),
      .acc_addr   (acc_addr),
      .acc_op     (acc_op),
      .acc_payload(acc_payload),
      .acc_start  (acc_start),
      .acc_clear  (acc_clear),
      .res_sel    (res_sel),
      .tx_data    (tx_data),
      .tx_send    (tx_send),
      .status     (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int send_cnt  = 0;
   int start_cnt = 0;
   int clear_cnt = 0;
   int dbl_cnt   = 0;
   int both_cnt  = 0;
   logic prev_send = 1'b0;
   logic [7:0] sent_data[$];
   logic [7:0] sent_sel[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (tx_send) begin
         send_cnt++;
         sent_data.push_back(tx_data);
         sent_sel.push_back(res_sel);
      end
      if (tx_send && prev_send) dbl_cnt++;
      prev_send = tx_send;
      if (acc_start) start_cnt++;
      if (acc_clear) clear_cnt++;
      if (acc_start && acc_clear) both_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] data_at(input int i);
      return (i < sent_data.size()) ? sent_data[i] : 8'hXX;
   endfunction

   function automatic logic [7:0] sel_at(input int i);
      return (i < sent_sel.size()) ? sent_sel[i] : 8'hXX;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] a, input logic [7:0] op, input logic [31:0] pl);
      send_byte(a);
      send_byte(op);
      for (int i = PB - 1; i >= 0; i--) send_byte(pl[8*i +: 8]);
   endtask

   task automatic pulse_done();
      @(posedge clk); #1;
      acc_done = 1'b1;
      @(posedge clk); #1;
      acc_done = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int budget, input string tag);
      int k = 0;
      while (send_cnt < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(tag, send_cnt, n);
   endtask

   task automatic clear_log();
      sent_data.delete();
      sent_sel.delete();
   endtask

   int base, s0, c0, snap;

   initial begin
      rst      = 1'b1;
      rx_data  = '0;
      rx_valid = 1'b0;
      tx_busy  = 1'b0;
      acc_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_addr",    acc_addr,    8'h00);
      check("rst_op",      acc_op,      3'd0);
      check("rst_payload", acc_payload, 32'h0);
      check("rst_start",   acc_start,   1'b0);
      check("rst_clear",   acc_clear,   1'b0);
      check("rst_sel",     res_sel,     8'h00);
      check("rst_txdata",  tx_data,     8'h00);
      check("rst_txsend",  tx_send,     1'b0);
      check("rst_status",  status,      8'hAA);
      rst = 1'b0;

      // STATUS right after reset returns the signature; strobes from the EXEC cycle onward are dropped.
      clear_log(); base = send_cnt;
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      @(posedge clk); #1; rx_data = 8'h00; rx_valid = 1'b1;
      @(posedge clk); #1; rx_data = 8'h77;
      @(posedge clk); #1; rx_data = 8'h88;
      @(posedge clk); #1; rx_data = 8'h99;
      @(posedge clk); #1; rx_valid = 1'b0;
      wait_tx(base + 1, 50, "st_send_seen");
      repeat (10) @(posedge clk); #1;
      check("st_count",  send_cnt - base, 1);
      check("st_data",   data_at(0), 8'hAA);
      check("st_addr",   acc_addr,   8'h00);
      check("st_op",     acc_op,     3'd1);
      check("st_status", status,     8'h01);

      // ACC command: decode, single start pulse, 16 streamed result bytes.
      clear_log(); base = send_cnt; s0 = start_cnt; c0 = clear_cnt;
      send_pkt(8'h05, 8'h02, 32'hDEADBEEF);
      repeat (4) @(posedge clk); #1;
      check("acc_addr",    acc_addr,    8'h05);
      check("acc_op",      acc_op,      3'd2);
      check("acc_payload", acc_payload, 32'hDEADBEEF);
      check("acc_start_n", start_cnt - s0, 1);
      send_byte(8'h33);
      repeat (3) @(posedge clk); #1;
      check("acc_wait_addr", acc_addr, 8'h05);
      check("acc_wait_tx",   send_cnt - base, 0);
      pulse_done();
      wait_tx(base + RW, 200, "acc_sends");
      repeat (6) @(posedge clk); #1;
      check("acc_count", send_cnt - base, RW);
      for (int i = 0; i < RW; i++) begin
         check($sformatf("acc_sel%0d", i),  sel_at(i),  i);
         check($sformatf("acc_data%0d", i), data_at(i), i ^ 8'h5A);
      end
      check("acc_clear_n", clear_cnt - c0, 0);
      check("acc_status",  status, 8'h01);

      // ACC response with TX held busy for 100 cycles mid-stream.
      clear_log(); base = send_cnt;
      send_pkt(8'h09, 8'h02, 32'h01020304);
      repeat (4) @(posedge clk);
      pulse_done();
      wait_tx(base + 3, 50, "bsy_first3");
      tx_busy = 1'b1;
      repeat (2) @(posedge clk);
      snap = send_cnt;
      repeat (100) @(posedge clk);
      check("bsy_hold", send_cnt, snap);
      #1 tx_busy = 1'b0;
      wait_tx(base + RW, 300, "bsy_sends");
      repeat (6) @(posedge clk); #1;
      check("bsy_count", send_cnt - base, RW);
      for (int i = 0; i < RW; i++) begin
         check($sformatf("bsy_sel%0d", i),  sel_at(i),  i);
         check($sformatf("bsy_data%0d", i), data_at(i), i ^ 8'h5A);
      end

      // Inter-byte timeout aborts a partial packet.
      clear_log(); base = send_cnt;
      send_byte(8'h05); send_byte(8'h00);
      repeat (TMO + 10) @(posedge clk); #1;
      check("tmo_status", status, 8'h14);
      check("tmo_nosend", send_cnt - base, 0);

      // WRITE with a byte gap just under the timeout still completes with ACK.
      clear_log(); base = send_cnt; s0 = start_cnt; c0 = clear_cnt;
      send_byte(8'h07); send_byte(8'h00); send_byte(8'h11);
      repeat (TMO - 4) @(posedge clk);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      wait_tx(base + 1, 50, "wr_send_seen");
      repeat (6) @(posedge clk); #1;
      check("wr_count",   send_cnt - base, 1);
      check("wr_data",    data_at(0), 8'h06);
      check("wr_payload", acc_payload, 32'h11223344);
      check("wr_clear_n", clear_cnt - c0, 1);
      check("wr_start_n", start_cnt - s0, 0);
      check("wr_status",  status, 8'h15);

      // Illegal opcode answers NAK.
      clear_log(); base = send_cnt; c0 = clear_cnt;
      send_pkt(8'h03, 8'h07, 32'h0);
      wait_tx(base + 1, 50, "nak_send_seen");
      repeat (6) @(posedge clk); #1;
      check("nak_count",   send_cnt - base, 1);
      check("nak_data",    data_at(0), 8'h15);
      check("nak_clear_n", clear_cnt - c0, 0);
      check("nak_status",  status, 8'h18);

      // Reset on the third LOAD byte.
      clear_log(); base = send_cnt;
      send_byte(8'h05); send_byte(8'h02);
      @(posedge clk); #1; rx_data = 8'hAA; rx_valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1; rx_valid = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      check("rl_addr",    acc_addr,    8'h00);
      check("rl_op",      acc_op,      3'd0);
      check("rl_payload", acc_payload, 32'h0);
      check("rl_sel",     res_sel,     8'h00);
      check("rl_txdata",  tx_data,     8'h00);
      check("rl_status",  status,      8'hAA);

      // Next packet decodes cleanly, then reset while waiting on the accelerator.
      s0 = start_cnt;
      send_pkt(8'h0C, 8'h02, 32'hCAFEBABE);
      repeat (4) @(posedge clk); #1;
      check("rw_addr",    acc_addr,    8'h0C);
      check("rw_payload", acc_payload, 32'hCAFEBABE);
      check("rw_start_n", start_cnt - s0, 1);
      rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      check("rw_rst_addr",    acc_addr,    8'h00);
      check("rw_rst_payload", acc_payload, 32'h0);
      check("rw_rst_status",  status,      8'hAA);
      pulse_done();
      repeat (20) @(posedge clk); #1;
      check("rw_nosend", send_cnt - base, 0);

      // CLEAR after reset acknowledges normally.
      clear_log(); base = send_cnt; c0 = clear_cnt;
      send_pkt(8'h01, 8'h03, 32'h0);
      wait_tx(base + 1, 50, "clr_send_seen");
      repeat (6) @(posedge clk); #1;
      check("clr_data",    data_at(0), 8'h06);
      check("clr_addr",    acc_addr,   8'h01);
      check("clr_clear_n", clear_cnt - c0, 1);
      check("clr_status",  status,     8'h01);

      check("dbl_send",      dbl_cnt,  0);
      check("start_clr_ovl", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
